// File: rtl/alu_seq_unit.sv
// Execute-stage integer unit: RV32I ALU ops in one cycle,
// RV32M multiply/divide iterated one bit per cycle.
module alu_seq_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_DONE
  } state_t;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
  } op_t;

  state_t          r_state;
  op_t             r_op;
  logic [SW-1:0]   r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [2*XLEN-1:0] r_mc;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0] r_x;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;

  op_t             w_op;
  op_t             w_base;
  op_t             w_mop;
  logic [SW-1:0]   w_sh;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_am;
  logic [XLEN-1:0] w_bm;
  logic            w_is_mul;
  logic            w_is_div;
  logic            w_bz;
  logic            w_ovf;
  logic            w_iter;
  logic            w_last;
  logic [XLEN-1:0] w_res1;

  always_comb begin
    w_base = OP_ADD;
    unique case (func3)
      3'b000: w_base = OP_ADD;
      3'b001: w_base = OP_SLL;
      3'b010: w_base = OP_SLT;
      3'b011: w_base = OP_SLTU;
      3'b100: w_base = OP_XOR;
      3'b101: w_base = OP_SRL;
      3'b110: w_base = OP_OR;
      3'b111: w_base = OP_AND;
      default: w_base = OP_ADD;
    endcase
    w_mop = OP_MUL;
    unique case (func3)
      3'b000: w_mop = OP_MUL;
      3'b001: w_mop = OP_MULH;
      3'b010: w_mop = OP_MULHSU;
      3'b011: w_mop = OP_MULHU;
      3'b100: w_mop = OP_DIV;
      3'b101: w_mop = OP_DIVU;
      3'b110: w_mop = OP_REM;
      3'b111: w_mop = OP_REMU;
      default: w_mop = OP_MUL;
    endcase
  end

  always_comb begin
    w_op = OP_ILL;
    unique case (alu_op)
      2'b00: w_op = OP_ADD;
      2'b01: w_op = OP_SUB;
      2'b10: begin
        if (func7 == 7'b0000000) w_op = w_base;
        else if (func7 == 7'b0000001) w_op = w_mop;
        else if (func7 == 7'b0100000) begin
          if (func3 == 3'b000) w_op = OP_SUB;
          else if (func3 == 3'b101) w_op = OP_SRA;
        end
      end
      2'b11: begin
        w_op = w_base;
        if (func3 == 3'b001 && func7 != 7'b0000000)
          w_op = OP_ILL;
        if (func3 == 3'b101) begin
          if (func7 == 7'b0100000) w_op = OP_SRA;
          else if (func7 != 7'b0000000) w_op = OP_ILL;
        end
      end
      default: w_op = OP_ILL;
    endcase
  end

  // Signed ops run on magnitudes; the sign is restored at the end.
  assign w_sh = b[SW-1:0];
  assign w_sa = a[XLEN-1] && (w_op == OP_MULH || w_op == OP_MULHSU ||
                              w_op == OP_DIV || w_op == OP_REM);
  assign w_sb = b[XLEN-1] && (w_op == OP_MULH ||
                              w_op == OP_DIV || w_op == OP_REM);
  assign w_am = w_sa ? -a : a;
  assign w_bm = w_sb ? -b : b;
  assign w_is_mul = (w_op == OP_MUL) || (w_op == OP_MULH) ||
                    (w_op == OP_MULHSU) || (w_op == OP_MULHU);
  assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU) ||
                    (w_op == OP_REM) || (w_op == OP_REMU);
  assign w_bz  = (b == '0);
  assign w_ovf = (w_op == OP_DIV || w_op == OP_REM) &&
                 (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign w_iter = w_is_mul || (w_is_div && !w_bz && !w_ovf);
  assign w_last = (r_cnt == SW'(XLEN-1));

  always_comb begin
    w_res1 = '0;
    unique case (w_op)
      OP_ADD:  w_res1 = a + b;
      OP_SUB:  w_res1 = a - b;
      OP_SLL:  w_res1 = a << w_sh;
      OP_SLT:  w_res1 = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: w_res1 = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:  w_res1 = a ^ b;
      OP_SRL:  w_res1 = a >> w_sh;
      OP_SRA:  w_res1 = $signed(a) >>> w_sh;
      OP_OR:   w_res1 = a | b;
      OP_AND:  w_res1 = a & b;
      OP_DIV, OP_DIVU: w_res1 = w_bz ? '1 : a;
      OP_REM, OP_REMU: w_res1 = w_bz ? a : '0;
      default: w_res1 = '0;
    endcase
  end

  logic [2*XLEN-1:0] w_prod_nx;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN:0]     w_rs;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_nx;
  logic [XLEN-1:0]   w_quo_nx;
  logic [XLEN-1:0]   w_div_res;

  assign w_prod_nx = r_prod + (r_x[0] ? r_mc : '0);
  assign w_prod_s  = r_neg_q ? -w_prod_nx : w_prod_nx;
  assign w_mul_res = (r_op == OP_MUL) ? w_prod_s[XLEN-1:0]
                                      : w_prod_s[2*XLEN-1:XLEN];

  // Restoring step: shift in next dividend bit, subtract if it fits.
  assign w_rs     = {r_rem, r_x[XLEN-1]};
  assign w_diff   = w_rs - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[XLEN];
  assign w_rem_nx = w_ge ? w_diff[XLEN-1:0] : w_rs[XLEN-1:0];
  assign w_quo_nx = {r_x[XLEN-2:0], w_ge};
  assign w_div_res = (r_op == OP_DIV || r_op == OP_DIVU)
                   ? (r_neg_q ? -w_quo_nx : w_quo_nx)
                   : (r_neg_r ? -w_rem_nx : w_rem_nx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      illegal <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_op    <= w_op;
            r_cnt   <= '0;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_mc    <= {{XLEN{1'b0}}, w_am};
            r_prod  <= '0;
            r_rem   <= '0;
            r_dvs   <= w_bm;
            r_x     <= w_is_mul ? w_bm : w_am;
            if (w_iter) begin
              r_state <= w_is_mul ? S_MUL : S_DIV;
              busy    <= 1'b1;
            end else begin
              r_state <= S_DONE;
              done    <= 1'b1;
              result  <= w_res1;
              illegal <= (w_op == OP_ILL);
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MUL: begin
          r_prod <= w_prod_nx;
          r_mc   <= r_mc << 1;
          r_x    <= r_x >> 1;
          if (w_last) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= w_mul_res;
            illegal <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nx;
          r_x   <= w_quo_nx;
          if (w_last) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= w_div_res;
            illegal <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  alu_op;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        illegal;

  int n_chk = 0;
  int n_err = 0;

  string base_n[8] = '{"ADD", "SLL", "SLT", "SLTU",
                       "XOR", "SRL", "OR", "AND"};
  string m_n[8] = '{"MUL", "MULH", "MULHSU", "MULHU",
                    "DIV", "DIVU", "REM", "REMU"};

  always #5 clk = ~clk;

  alu_seq_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .alu_op(alu_op), .func3(func3), .func7(func7),
    .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic string dec(input logic [1:0] aop,
                                input logic [2:0] f3,
                                input logic [6:0] f7);
    if (aop == 2'd0) return "ADD";
    if (aop == 2'd1) return "SUB";
    if (aop == 2'd2) begin
      if (f7 == 7'h00) return base_n[f3];
      if (f7 == 7'h01) return m_n[f3];
      if (f7 == 7'h20) begin
        if (f3 == 3'd0) return "SUB";
        if (f3 == 3'd5) return "SRA";
      end
      return "ILL";
    end
    if (f3 == 3'd1) begin
      if (f7 == 7'h00) return "SLL";
      return "ILL";
    end
    if (f3 == 3'd5) begin
      if (f7 == 7'h00) return "SRL";
      if (f7 == 7'h20) return "SRA";
      return "ILL";
    end
    return base_n[f3];
  endfunction

  task automatic model(input string op, input logic [31:0] x,
                       input logic [31:0] y, output logic [31:0] r,
                       output logic ill, output int lat);
    int sx, sy;
    longint p;
    logic [63:0] u;
    bit ovf;
    sx = x;
    sy = y;
    r = '0;
    ill = 1'b0;
    lat = 1;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (op)
      "ADD":  r = x + y;
      "SUB":  r = x - y;
      "SLL":  r = x << y[4:0];
      "SLT":  r = (sx < sy) ? 32'd1 : 32'd0;
      "SLTU": r = (x < y) ? 32'd1 : 32'd0;
      "XOR":  r = x ^ y;
      "SRL":  r = x >> y[4:0];
      "SRA":  r = sx >>> y[4:0];
      "OR":   r = x | y;
      "AND":  r = x & y;
      "MUL": begin
        u = {32'd0, x} * {32'd0, y};
        r = u[31:0];
        lat = 33;
      end
      "MULH": begin
        p = longint'(sx) * longint'(sy);
        r = p[63:32];
        lat = 33;
      end
      "MULHSU": begin
        p = longint'(sx) * longint'({32'd0, y});
        r = p[63:32];
        lat = 33;
      end
      "MULHU": begin
        u = {32'd0, x} * {32'd0, y};
        r = u[63:32];
        lat = 33;
      end
      "DIV": begin
        if (y == 0) r = '1;
        else if (ovf) r = x;
        else begin r = sx / sy; lat = 33; end
      end
      "DIVU": begin
        if (y == 0) r = '1;
        else begin r = x / y; lat = 33; end
      end
      "REM": begin
        if (y == 0) r = x;
        else if (ovf) r = '0;
        else begin r = sx % sy; lat = 33; end
      end
      "REMU": begin
        if (y == 0) r = x;
        else begin r = x % y; lat = 33; end
      end
      default: ill = 1'b1;
    endcase
  endtask

  // Called at a falling edge; start is seen on the next rising edge.
  task automatic run_op(input string tag, input logic [1:0] aop,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic ei,
                        input int el, input int poke);
    int lat;
    int nb;
    bit got;
    alu_op = aop;
    func3 = f3;
    func7 = f7;
    a = x;
    b = y;
    start = 1'b1;
    lat = 0;
    nb = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) got = 1'b1;
      else if (busy) nb++;
      if (lat == 1) begin
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        func3 = 3'($urandom);
      end
      if (lat == poke && !got) begin
        start = 1'b1;
        alu_op = 2'b00;
      end
      if (lat == poke + 1) start = 1'b0;
    end
    chk({tag, "/lat"}, got ? lat : 0, el);
    chk({tag, "/busy_cycles"}, nb, el - 1);
    chk({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "/result"}, result, er);
    chk({tag, "/illegal"}, 32'(illegal), 32'(ei));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic rnd_op();
    logic [1:0] aop;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] x, y, er;
    logic ei;
    int el;
    string op;
    aop = 2'($urandom);
    f3 = 3'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    x = pick();
    y = pick();
    op = dec(aop, f3, f7);
    model(op, x, y, er, ei, el);
    run_op({"rnd_", op}, aop, f3, f7, x, y, er, ei, el, 0);
  endtask

  initial begin
    int nd;
    int gap;
    rst = 1'b1;
    start = 1'b0;
    alu_op = '0;
    func3 = '0;
    func7 = '0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("reset/busy", 32'(busy), 32'd0);
    chk("reset/done", 32'(done), 32'd0);
    chk("reset/result", result, 32'd0);
    chk("reset/illegal", 32'(illegal), 32'd0);
    rst = 1'b0;

    run_op("add", 2'd2, 3'd0, 7'h00, 32'd5, 32'd7, 32'd12, 1'b0, 1, 0);
    run_op("sub_b2b", 2'd2, 3'd0, 7'h20, 32'd5, 32'd7,
           32'hFFFF_FFFE, 1'b0, 1, 0);
    run_op("srai", 2'd3, 3'd5, 7'h20, 32'h8000_0000, 32'd4,
           32'hF800_0000, 1'b0, 1, 0);
    run_op("srli", 2'd3, 3'd5, 7'h00, 32'h8000_0000, 32'd4,
           32'h0800_0000, 1'b0, 1, 0);
    run_op("mulh", 2'd2, 3'd1, 7'h01, 32'hFFFF_FFFF, 32'd2,
           32'hFFFF_FFFF, 1'b0, 33, 0);
    run_op("mulhu", 2'd2, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'd2,
           32'h0000_0001, 1'b0, 33, 0);
    run_op("mul", 2'd2, 3'd0, 7'h01, 32'hFFFF_FFFF, 32'd2,
           32'hFFFF_FFFE, 1'b0, 33, 0);
    run_op("div", 2'd2, 3'd4, 7'h01, -32'sd7, 32'd2,
           32'hFFFF_FFFD, 1'b0, 33, 0);
    run_op("rem", 2'd2, 3'd6, 7'h01, -32'sd7, 32'd2,
           32'hFFFF_FFFF, 1'b0, 33, 0);
    run_op("div_by0", 2'd2, 3'd4, 7'h01, 32'd100, 32'd0,
           32'hFFFF_FFFF, 1'b0, 1, 0);
    run_op("remu_by0", 2'd2, 3'd7, 7'h01, 32'd100, 32'd0,
           32'd100, 1'b0, 1, 0);
    run_op("div_ovf", 2'd2, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1'b0, 1, 0);
    run_op("rem_ovf", 2'd2, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 1'b0, 1, 0);
    run_op("illegal", 2'd2, 3'd0, 7'h02, 32'd3, 32'd4,
           32'd0, 1'b1, 1, 0);
    run_op("divu_poke", 2'd2, 3'd5, 7'h01, 32'd1000, 32'd7,
           32'd142, 1'b0, 33, 5);

    alu_op = 2'd2;
    func3 = 3'd5;
    func7 = 7'h01;
    a = 32'd1000;
    b = 32'd7;
    start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst/busy", 32'(busy), 32'd0);
    chk("mid_rst/done", 32'(done), 32'd0);
    chk("mid_rst/result", result, 32'd0);
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_rst/no_done", nd, 0);
    run_op("add_after_rst", 2'd2, 3'd0, 7'h00, 32'd1, 32'd1,
           32'd2, 1'b0, 1, 0);

    for (int k = 0; k < 250; k++) begin
      rnd_op();
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        @(negedge clk);
        chk("done_pulse_end", 32'(done), 32'd0);
        repeat (gap - 1) @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, sequential successor to the combinational ALU decode path. It decodes ALUOp/func3/func7 into the full RV32I integer op set plus the RV32M multiply/divide ops, and executes them. Single-cycle ops complete in one cycle; MUL*/DIV*/REM* run iteratively under an FSM with a start/busy/done handshake. It sits in the execute stage and replaces the separate ALU controller and ALU pair.

## Interface
- XLEN, 32, datapath width; power of two, 8..64.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE or DONE state.
- alu_op  in  2  00 S-type (ADD), 01 B-type (SUB), 10 R-type, 11 I-type.
- func3  in  3  instr[14:12].
- func7  in  7  instr[31:25]; bit 5 selects SUB/SRA, value 0000001 selects M ops.
- a  in  XLEN  operand 1 (rs1).
- b  in  XLEN  operand 2 (rs2 or immediate).
- busy  out  1  high while an iterative op is running.
- done  out  1  one-cycle pulse; result/illegal valid.
- result  out  XLEN  registered result; held until the next done.
- illegal  out  1  valid with done; unsupported encoding.

## Operation
- On accept, latch alu_op, func3, func7, a and b. Inputs are ignored after accept.
- Decode:
  - S → ADD; B → SUB.
  - R with func7=0000000: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - R with func7=0100000: 000 SUB, 101 SRA.
  - R with func7=0000001: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - I: 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND (func7 ignored). 001 SLL needs func7=0000000. 101 needs func7 0000000 (SRL) or 0100000 (SRA).
  - Any other combination is illegal: result=0, illegal=1, single-cycle path.
- Shift amount is b[$clog2(XLEN)-1:0].
- SLT is signed, SLTU unsigned; the result is 0 or 1, zero-extended.
- ADD/SUB wrap modulo 2^XLEN.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE/DONE + start, single-cycle op → DONE, with the result registered.
  - IDLE/DONE + start, M multiply → MUL; iteration counter = 0.
  - IDLE/DONE + start, M divide/rem → DIV; counter = 0. Exception: divisor 0 or signed overflow goes straight to DONE.
  - MUL/DIV → DONE when counter = XLEN-1; otherwise counter increments.
  - DONE without start → IDLE.
- Multiply: radix-2 shift-add on operand magnitudes into a 2·XLEN product.
  - Signedness: MULH treats a and b as signed. MULHSU treats a as signed, b as unsigned. MUL/MULHU treat both as unsigned.
  - Negate the product when the signs differ.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- Divide: restoring, one quotient bit per cycle on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Sign fix is applied on the transition into DONE.
- Divide special cases:
  - b=0: DIV/DIVU → all ones; REM/REMU → a.
  - DIV with a=most-negative and b=-1 → most-negative; REM → 0.

## Timing
- Reset values: busy=0, done=0, result=0, illegal=0; state IDLE; counter 0. Reset mid-operation discards the op; no done is issued for it.
- Start accepted at edge N:
  - Single-cycle ops and divide special cases: done=1 in cycle N+1.
  - Iterative ops: busy=1 in cycles N+1..N+XLEN, done=1 and busy=0 in cycle N+XLEN+1.
- done is exactly one cycle, unless a new single-cycle op is accepted in the DONE cycle. In that case done stays high with the new result the next cycle, giving a throughput of 1 op/cycle.
- start while busy=1 is ignored; no queuing.
- result and illegal change only on a done cycle or on reset.

## Test plan
- R ADD, a=5, b=7, start at N → done at N+1, result=12, illegal=0. Then SUB (func7=0100000) in the DONE cycle → done at N+2, result=0xFFFFFFFE.
- I SRA, a=0x80000000, b=4, func7=0100000, func3=101 → result=0xF8000000. Same with func7=0 (SRL) → 0x08000000.
- MULH, a=0xFFFFFFFF, b=2 → busy for 32 cycles, done at N+33, result=0xFFFFFFFF. MULHU → 0x00000001. MUL → 0xFFFFFFFE.
- DIV, a=-7, b=2 → done at N+33, result=-3; REM → -1. DIV a=100, b=0 → done at N+1, result=0xFFFFFFFF; REMU → 100. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- R with func7=0000010 → done at N+1, illegal=1, result=0. A start pulse at N+5 of a DIVU is ignored, and the DIVU result is unaffected.
- rst asserted at cycle N+10 of a DIVU → busy=0 and result=0 at N+11, no done pulse. A following ADD 1+1 → done at the next cycle, result=2.
